// File: rtl/axis_variable_multi.sv
// Change-triggered multi-channel sampler: each input channel that changes is queued
// and offered on one AXI-Stream master, round-robin, with per-channel overrun flags.
module axis_variable_multi #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CHANNELS         = 4,
   parameter int REFRESH_CYCLES   = 0,
   localparam int CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                                 m_axis_aclk,
   input  logic                                 m_axis_areset,
   input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]                  overrun_clr,
   input  logic                                 m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
   output logic [CW-1:0]                        m_axis_tuser,
   output logic                                 m_axis_tvalid,
   output logic [CHANNELS-1:0]                  overrun
);

   localparam int W = AXIS_TDATA_WIDTH;

   logic [W-1:0]        r_shadow [CHANNELS];
   logic [CHANNELS-1:0] r_pending;
   logic [CHANNELS-1:0] r_overrun;
   logic [CW-1:0]       r_rr_ptr;
   logic [W-1:0]        r_tdata;
   logic [CW-1:0]       r_tuser;
   logic                r_tvalid;

   logic [CHANNELS-1:0] w_change;
   logic [CHANNELS-1:0] w_grant_oh;
   logic [CHANNELS-1:0] w_ovr_set;
   logic                w_free;
   logic                w_grant_vld;
   logic                w_take;
   logic [CW-1:0]       w_grant;
   logic [CW-1:0]       w_rr_next;
   logic                w_refresh;

   assign w_free = !r_tvalid || m_axis_tready;
   assign w_take = w_free && w_grant_vld;

   always_comb begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         w_change[k] = (data_in[k*W +: W] != r_shadow[k]);
      end
   end

   // First pending channel at or after rr_ptr, wrapping modulo CHANNELS.
   always_comb begin
      int unsigned w_idx;
      w_grant_vld = 1'b0;
      w_grant     = '0;
      w_idx       = 0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_idx = 32'(r_rr_ptr) + i;
         if (w_idx >= CHANNELS) begin
            w_idx = w_idx - CHANNELS;
         end
         if (!w_grant_vld && r_pending[w_idx]) begin
            w_grant_vld = 1'b1;
            w_grant     = CW'(w_idx);
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         w_grant_oh[k] = w_take && (w_grant == CW'(k));
      end
   end

   assign w_rr_next = (w_grant == CW'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;

   // A change on the channel being granted this edge re-arms pending without counting as overrun.
   assign w_ovr_set = w_change & r_pending & ~w_grant_oh;

   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         logic [RW-1:0] r_refresh_cnt;

         assign w_refresh = (r_refresh_cnt == RW'(REFRESH_CYCLES - 1));

         always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
            if (m_axis_areset) begin
               r_refresh_cnt <= '0;
            end else if (w_refresh) begin
               r_refresh_cnt <= '0;
            end else begin
               r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
         end
      end else begin : g_no_refresh
         assign w_refresh = 1'b0;
      end
   endgenerate

   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            r_shadow[k] <= '0;
         end
         r_pending <= '0;
         r_overrun <= '0;
         r_rr_ptr  <= '0;
         r_tdata   <= '0;
         r_tuser   <= '0;
         r_tvalid  <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            r_shadow[k] <= data_in[k*W +: W];
         end
         r_pending <= w_change | (r_pending & ~w_grant_oh) | {CHANNELS{w_refresh}};
         r_overrun <= w_ovr_set | (r_overrun & ~overrun_clr);
         if (w_free) begin
            if (w_grant_vld) begin
               r_tdata  <= r_shadow[w_grant];
               r_tuser  <= w_grant;
               r_tvalid <= 1'b1;
               r_rr_ptr <= w_rr_next;
            end else begin
               r_tvalid <= 1'b0;
            end
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tvalid = r_tvalid;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_axis_variable_multi.sv
// Scoreboard bench for axis_variable_multi: directed stimulus pushes expected beats,
// a negedge monitor pops them on each handshake; a second instance exercises refresh.
module tb_axis_variable_multi;

   localparam int W  = 32;
   localparam int CH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [CH*W-1:0]   data_in;
   logic [CH-1:0]     ovr_clr;
   logic              tready;
   logic [W-1:0]      tdata;
   logic [1:0]        tuser;
   logic              tvalid;
   logic [CH-1:0]     overrun;

   logic              rst_ref;
   logic [CH*W-1:0]   ref_data;
   logic [W-1:0]      ref_tdata;
   logic [1:0]        ref_tuser;
   logic              ref_tvalid;
   logic [CH-1:0]     ref_overrun;

   axis_variable_multi #(
      .AXIS_TDATA_WIDTH (W),
      .CHANNELS         (CH),
      .REFRESH_CYCLES   (0)
   ) u_dut (
      .m_axis_aclk   (clk),
      .m_axis_areset (rst),
      .data_in       (data_in),
      .overrun_clr   (ovr_clr),
      .m_axis_tready (tready),
      .m_axis_tdata  (tdata),
      .m_axis_tuser  (tuser),
      .m_axis_tvalid (tvalid),
      .overrun       (overrun)
   );

   axis_variable_multi #(
      .AXIS_TDATA_WIDTH (W),
      .CHANNELS         (CH),
      .REFRESH_CYCLES   (16)
   ) u_ref (
      .m_axis_aclk   (clk),
      .m_axis_areset (rst_ref),
      .data_in       (ref_data),
      .overrun_clr   ('0),
      .m_axis_tready (1'b1),
      .m_axis_tdata  (ref_tdata),
      .m_axis_tuser  (ref_tuser),
      .m_axis_tvalid (ref_tvalid),
      .overrun       (ref_overrun)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  user;
      logic [31:0] data;
   } beat_t;

   beat_t sb[$];
   beat_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      data_in[k*W +: W] = v;
   endtask

   task automatic push(input int u, input logic [31:0] d);
      beat_t b;
      b.user = 2'(u);
      b.data = d;
      sb.push_back(b);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      data_in = '0;
      ovr_clr = '0;
      step(2);
      rst = 1'b0;
   endtask

   // Main DUT monitor: every handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && tvalid && tready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tuser=%0d tdata=0x%0h expected no beat", tuser, tdata);
         end else begin
            mon_e = sb.pop_front();
            chk("beat_tuser", 64'(tuser), 64'(mon_e.user));
            chk("beat_tdata", 64'(tdata), 64'(mon_e.data));
         end
      end
   end

   // Refresh instance monitor: strict round-robin order, fixed data, 16-clock period.
   int ref_cyc       = 0;
   int ref_next      = 0;
   int ref_zero_cnt  = 0;
   int ref_last_zero = 0;

   always @(negedge clk) begin
      ref_cyc++;
      if (!rst_ref && ref_tvalid) begin
         chk("ref_tuser", 64'(ref_tuser), 64'(ref_next));
         chk("ref_tdata", 64'(ref_tdata), 64'(32'h100 + 32'(ref_next)));
         if (ref_next == 0) begin
            ref_zero_cnt++;
            if (ref_zero_cnt >= 3) begin
               chk("ref_period", 64'(ref_cyc - ref_last_zero), 64'd16);
            end
            ref_last_zero = ref_cyc;
         end
         ref_next = (ref_next + 1) % CH;
      end
   end

   initial begin
      rst      = 1'b1;
      rst_ref  = 1'b1;
      data_in  = '0;
      ovr_clr  = '0;
      tready   = 1'b1;
      ref_data = {32'h103, 32'h102, 32'h101, 32'h100};
      step(2);
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tdata", 64'(tdata), 64'd0);
      chk("rst_tuser", 64'(tuser), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      rst     = 1'b0;
      rst_ref = 1'b0;
      step(3);
      chk("idle_tvalid", 64'(tvalid), 64'd0);

      // Single change on ch2: two-edge latency, one beat, then idle with held data.
      set_ch(2, 32'hA5);
      push(2, 32'hA5);
      step(1);
      chk("single_lat1_tvalid", 64'(tvalid), 64'd0);
      step(1);
      chk("single_tvalid", 64'(tvalid), 64'd1);
      chk("single_tdata", 64'(tdata), 64'hA5);
      chk("single_tuser", 64'(tuser), 64'd2);
      step(1);
      chk("single_after_tvalid", 64'(tvalid), 64'd0);
      chk("single_hold_tdata", 64'(tdata), 64'hA5);
      chk("single_hold_tuser", 64'(tuser), 64'd2);

      // Round robin: all four together, then ch0 and ch3 with rr_ptr back at 0.
      do_reset();
      set_ch(0, 32'h10); set_ch(1, 32'h20); set_ch(2, 32'h30); set_ch(3, 32'h40);
      push(0, 32'h10); push(1, 32'h20); push(2, 32'h30); push(3, 32'h40);
      step(2);
      chk("rr_first_tuser", 64'(tuser), 64'd0);
      step(3);
      chk("rr_last_tuser", 64'(tuser), 64'd3);
      chk("rr_last_tvalid", 64'(tvalid), 64'd1);
      step(1);
      chk("rr_done_tvalid", 64'(tvalid), 64'd0);
      set_ch(0, 32'h50); set_ch(3, 32'h60);
      push(0, 32'h50); push(3, 32'h60);
      step(2);
      chk("rr2_first_tuser", 64'(tuser), 64'd0);
      step(1);
      chk("rr2_second_tuser", 64'(tuser), 64'd3);
      step(2);

      // Backpressure and coalescing on ch1 while ch0 waits.
      do_reset();
      tready = 1'b0;
      set_ch(1, 32'h11);
      push(1, 32'h11);
      step(2);
      set_ch(1, 32'h22);
      set_ch(0, 32'h0A);
      step(1);
      set_ch(1, 32'h33);
      step(1);
      push(0, 32'h0A);
      push(1, 32'h33);
      step(3);
      chk("bp_tvalid", 64'(tvalid), 64'd1);
      chk("bp_tdata", 64'(tdata), 64'h11);
      chk("bp_tuser", 64'(tuser), 64'd1);
      chk("bp_overrun", 64'(overrun), 64'b0010);
      tready = 1'b1;
      step(3);
      chk("bp_drain_tvalid", 64'(tvalid), 64'd0);
      chk("bp_overrun_sticky", 64'(overrun), 64'b0010);
      ovr_clr = 4'b0010;
      step(1);
      ovr_clr = '0;
      chk("bp_overrun_clr", 64'(overrun), 64'd0);

      // New overrun on the same edge as its clear: the set wins.
      tready = 1'b0;
      set_ch(2, 32'h1);
      push(2, 32'h1);
      step(2);
      set_ch(3, 32'h1);
      step(1);
      set_ch(3, 32'h2);
      ovr_clr = 4'b1000;
      step(1);
      ovr_clr = '0;
      chk("ovr_set_wins", 64'(overrun), 64'b1000);
      push(3, 32'h2);
      tready = 1'b1;
      step(3);
      chk("sw_drain_tvalid", 64'(tvalid), 64'd0);

      // Grant and change on the same edge: resent with new value, no overrun.
      do_reset();
      set_ch(0, 32'h3);
      push(0, 32'h3);
      step(1);
      set_ch(0, 32'h5);
      push(0, 32'h5);
      step(1);
      chk("same_first_tdata", 64'(tdata), 64'h3);
      step(1);
      chk("same_second_tvalid", 64'(tvalid), 64'd1);
      chk("same_second_tdata", 64'(tdata), 64'h5);
      chk("same_second_tuser", 64'(tuser), 64'd0);
      chk("same_overrun", 64'(overrun), 64'd0);
      step(2);

      // Async reset mid-transfer drops the beat; new data seen two edges after release.
      do_reset();
      tready = 1'b0;
      set_ch(1, 32'h9);
      step(2);
      set_ch(2, 32'h1);
      step(1);
      set_ch(2, 32'h2);
      step(1);
      chk("ar_pre_tvalid", 64'(tvalid), 64'd1);
      chk("ar_pre_overrun", 64'(overrun), 64'b0100);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_tvalid", 64'(tvalid), 64'd0);
      chk("ar_tdata", 64'(tdata), 64'd0);
      chk("ar_overrun", 64'(overrun), 64'd0);
      data_in = '0;
      set_ch(0, 32'h7);
      tready = 1'b1;
      step(2);
      rst = 1'b0;
      push(0, 32'h7);
      step(1);
      chk("ar_lat1_tvalid", 64'(tvalid), 64'd0);
      step(1);
      chk("ar_tvalid_after", 64'(tvalid), 64'd1);
      chk("ar_tdata_after", 64'(tdata), 64'h7);
      chk("ar_tuser_after", 64'(tuser), 64'd0);
      step(2);

      step(40);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("ref_refreshes_seen", 64'(ref_zero_cnt >= 4), 64'd1);
      chk("ref_overrun", 64'(ref_overrun), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
